keypad_operand_entry: RTL and testbench

KEYPAD_OPERAND_ENTRY -- requirements
Module: keypad_operand_entry

---
 rtl/keypad_pkg.sv | 31 +++
 rtl/keypad_scanner.sv | 139 +++++++++++++
 rtl/keypad_operand_entry.sv | 114 +++++++++++
 tb/tb_keypad_operand_entry.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared key codes, entry FSM states and the 4x4 keypad map
// for the keypad operand entry block.
package keypad_pkg;

    localparam logic [3:0] KEY_STAR   = 4'd10;
    localparam logic [3:0] KEY_HASH   = 4'd11;
    localparam logic [3:0] KEY_LETTER = 4'd12;
    localparam logic [3:0] KEY_NONE   = 4'd15;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        DONE    = 2'd2
    } entry_state_e;

    // Indexed by {row, col}; element 0 is row 0 / col 0.
    localparam logic [15:0][3:0] KEY_MAP = {
        KEY_LETTER, KEY_HASH,   4'd0, KEY_STAR,
        KEY_LETTER, 4'd9,       4'd8, 4'd7,
        KEY_LETTER, 4'd6,       4'd5, 4'd4,
        KEY_LETTER, 4'd3,       4'd2, 4'd1
    };

    function automatic logic [6:0] bcd_to_bin(
        input logic [3:0] tens,
        input logic [3:0] unit
    );
        return 7'({tens, 3'b000}) + 7'({tens, 1'b0}) + 7'(unit);
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Row scanner, column synchronizer, per-scan decode and debounce.
// Emits a one-cycle key_stb with key_code for each accepted press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] row_n,
    input  logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_stb
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int RW = $clog2(DEBOUNCE_SCANS + 1);

    logic [3:0]    sync1_q, sync2_q;
    logic [CW-1:0] div_q, div_d;
    logic [1:0]    row_q, row_d;
    logic [1:0]    hits_q, hits_d;
    logic [3:0]    acc_q, acc_d;
    logic [3:0]    cand_q, cand_d;
    logic [RW-1:0] run_q, run_d;
    logic          pressed_q, pressed_d;
    logic          armed_q, armed_d;
    logic [3:0]    code_q, code_d;
    logic          stb_q, stb_d;

    logic          slot_end, scan_done;
    logic [1:0]    row_hits, row_col, tot;
    logic [2:0]    sum;
    logic [3:0]    code_sel, scan_code;
    logic [RW-1:0] run_inc, run_new;

    assign row_n    = ~(4'b0001 << row_q);
    assign key_code = code_q;
    assign key_stb  = stb_q;

    always_comb begin
        row_hits = 2'd0;
        row_col  = 2'd0;
        for (int c = 0; c < 4; c++) begin
            if (!sync2_q[c]) begin
                row_hits = (row_hits == 2'd2) ? 2'd2 : row_hits + 2'd1;
                row_col  = 2'(c);
            end
        end
        sum       = {1'b0, hits_q} + {1'b0, row_hits};
        tot       = (sum >= 3'd2) ? 2'd2 : sum[1:0];
        code_sel  = (row_hits != 2'd0) ? KEY_MAP[{row_q, row_col}] : acc_q;
        scan_code = (tot == 2'd1) ? code_sel : KEY_NONE;
        slot_end  = (div_q == CW'(SCAN_DIV - 1));
        scan_done = slot_end && (row_q == 2'd3);
        run_inc   = run_q + RW'(1);
        run_new   = (scan_code == cand_q) ? run_inc : RW'(1);
    end

    always_comb begin
        div_d     = div_q + CW'(1);
        row_d     = row_q;
        hits_d    = hits_q;
        acc_d     = acc_q;
        cand_d    = cand_q;
        run_d     = run_q;
        pressed_d = pressed_q;
        armed_d   = armed_q;
        code_d    = code_q;
        stb_d     = 1'b0;
        if (slot_end) begin
            div_d  = '0;
            row_d  = row_q + 2'd1;
            hits_d = scan_done ? 2'd0 : tot;
            acc_d  = scan_done ? KEY_NONE : code_sel;
        end
        // Strobes are held off until a full release, also right after reset.
        if (scan_done) begin
            if (pressed_q || !armed_q) begin
                if (scan_code == KEY_NONE) begin
                    if (run_inc == RW'(DEBOUNCE_SCANS)) begin
                        armed_d   = 1'b1;
                        pressed_d = 1'b0;
                        run_d     = '0;
                        cand_d    = KEY_NONE;
                    end else begin
                        run_d = run_inc;
                    end
                end else begin
                    run_d = '0;
                end
            end else if (scan_code == KEY_NONE) begin
                run_d  = '0;
                cand_d = KEY_NONE;
            end else if (run_new == RW'(DEBOUNCE_SCANS)) begin
                stb_d     = 1'b1;
                code_d    = scan_code;
                pressed_d = 1'b1;
                run_d     = '0;
                cand_d    = KEY_NONE;
            end else begin
                cand_d = scan_code;
                run_d  = run_new;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 4'b1111;
            sync2_q   <= 4'b1111;
            div_q     <= '0;
            row_q     <= 2'd0;
            hits_q    <= 2'd0;
            acc_q     <= KEY_NONE;
            cand_q    <= KEY_NONE;
            run_q     <= '0;
            pressed_q <= 1'b0;
            armed_q   <= 1'b0;
            code_q    <= KEY_NONE;
            stb_q     <= 1'b0;
        end else begin
            sync1_q   <= col_n;
            sync2_q   <= sync1_q;
            div_q     <= div_d;
            row_q     <= row_d;
            hits_q    <= hits_d;
            acc_q     <= acc_d;
            cand_q    <= cand_d;
            run_q     <= run_d;
            pressed_q <= pressed_d;
            armed_q   <= armed_d;
            code_q    <= code_d;
            stb_q     <= stb_d;
        end
    end

endmodule

// File: rtl/keypad_operand_entry.sv
// Two-operand keypad entry: digits shift in as BCD, '#' commits
// operand A then operand B, '*' clears the entry in progress.
module keypad_operand_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] row_n,
    input  logic [3:0] col_n,
    output logic [6:0] operand_a,
    output logic [6:0] operand_b,
    output logic       valid,
    output logic       entry_sel,
    output logic [3:0] digit_tens,
    output logic [3:0] digit_unit
);

    entry_state_e state_q, state_d;
    logic [6:0]   op_a_q, op_a_d;
    logic [6:0]   op_b_q, op_b_d;
    logic [3:0]   tens_q, tens_d;
    logic [3:0]   unit_q, unit_d;
    logic         valid_q, valid_d;

    logic [3:0]   key_code;
    logic         key_stb;
    logic         is_digit;
    logic [6:0]   entry_bin;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_scanner (
        .clk      (clk),
        .rst      (rst),
        .row_n    (row_n),
        .col_n    (col_n),
        .key_code (key_code),
        .key_stb  (key_stb)
    );

    assign operand_a  = op_a_q;
    assign operand_b  = op_b_q;
    assign valid      = valid_q;
    assign entry_sel  = (state_q != ENTER_A);
    assign digit_tens = tens_q;
    assign digit_unit = unit_q;
    assign is_digit   = (key_code <= 4'd9);
    assign entry_bin  = bcd_to_bin(tens_q, unit_q);

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        tens_d  = tens_q;
        unit_d  = unit_q;
        valid_d = 1'b0;
        if (key_stb) begin
            if (state_q == DONE) begin
                if (is_digit) begin
                    state_d = ENTER_A;
                    tens_d  = 4'd0;
                    unit_d  = key_code;
                end
            end else begin
                unique case (1'b1)
                    is_digit: begin
                        tens_d = unit_q;
                        unit_d = key_code;
                    end
                    (key_code == KEY_STAR): begin
                        tens_d = 4'd0;
                        unit_d = 4'd0;
                    end
                    (key_code == KEY_HASH): begin
                        tens_d = 4'd0;
                        unit_d = 4'd0;
                        if (state_q == ENTER_A) begin
                            op_a_d  = entry_bin;
                            state_d = ENTER_B;
                        end else begin
                            op_b_d  = entry_bin;
                            valid_d = 1'b1;
                            state_d = DONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ENTER_A;
            op_a_q  <= 7'd0;
            op_b_q  <= 7'd0;
            tens_q  <= 4'd0;
            unit_q  <= 4'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            tens_q  <= tens_d;
            unit_q  <= unit_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Directed bench: a modelled 4x4 keypad drives col_n from row_n
// and held keys; outputs are checked with immediate assertions.
module tb_keypad_operand_entry;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [6:0] operand_a;
    logic [6:0] operand_b;
    logic       valid;
    logic       entry_sel;
    logic [3:0] digit_tens;
    logic [3:0] digit_unit;

    logic [15:0] keys = '0;
    int total = 0;
    int bad   = 0;
    int stb_cnt = 0;
    int valid_cnt = 0;
    int s0, v0;

    always #5 clk = ~clk;

    keypad_operand_entry #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .row_n      (row_n),
        .col_n      (col_n),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .valid      (valid),
        .entry_sel  (entry_sel),
        .digit_tens (digit_tens),
        .digit_unit (digit_unit)
    );

    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
    end

    always @(posedge clk) begin
        if (dut.u_scanner.key_stb === 1'b1) stb_cnt++;
        if (valid === 1'b1) valid_cnt++;
    end

    // 0..9 digits, 10 = '*', 11 = '#', 12 = 'A'
    function automatic int idx_of(input int k);
        if (k >= 1 && k <= 9) return ((k - 1) / 3) * 4 + (k - 1) % 3;
        if (k == 0)  return 13;
        if (k == 10) return 12;
        if (k == 11) return 14;
        return 3;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tap(input int k);
        keys[idx_of(k)] = 1'b1;
        repeat (96) @(posedge clk);
        keys = '0;
        repeat (96) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_row_n", row_n, 4'b1110);
        check("rst_op_a", operand_a, 0);
        check("rst_op_b", operand_b, 0);
        check("rst_valid", valid, 0);
        check("rst_sel", entry_sel, 0);
        check("rst_tens", digit_tens, 0);
        check("rst_unit", digit_unit, 0);
        repeat (70) @(posedge clk);
        @(negedge clk);
        check("row_onehot", 16'($countones(~row_n)), 1);

        // 8,1,# then 1,2,#
        v0 = valid_cnt;
        tap(8);
        check("a1_unit", digit_unit, 8);
        check("a1_sel", entry_sel, 0);
        tap(1);
        check("a2_tens", digit_tens, 8);
        check("a2_unit", digit_unit, 1);
        tap(11);
        check("a_commit", operand_a, 81);
        check("a_sel", entry_sel, 1);
        check("a_clr", digit_unit, 0);
        tap(1);
        tap(2);
        tap(11);
        check("b_commit", operand_b, 12);
        check("b_valid1", 16'(valid_cnt - v0), 1);
        check("b_sel", entry_sel, 1);
        check("b_tens", digit_tens, 0);

        // DONE ignores '#', '*' and letters; digit restarts A
        v0 = valid_cnt;
        tap(11);
        tap(10);
        tap(12);
        check("done_ignore_v", 16'(valid_cnt - v0), 0);
        check("done_ignore_s", entry_sel, 1);
        tap(4);
        check("done_sel", entry_sel, 0);
        check("done_unit", digit_unit, 4);
        check("done_tens", digit_tens, 0);
        check("done_op_a", operand_a, 81);
        check("done_op_b", operand_b, 12);

        // 1,2,3,# then 4,*,7,#
        do_reset();
        repeat (70) @(posedge clk);
        tap(1);
        tap(2);
        tap(3);
        check("drop_tens", digit_tens, 2);
        check("drop_unit", digit_unit, 3);
        tap(11);
        check("drop_op_a", operand_a, 23);
        v0 = valid_cnt;
        tap(4);
        tap(10);
        check("star_tens", digit_tens, 0);
        check("star_unit", digit_unit, 0);
        check("star_sel", entry_sel, 1);
        tap(7);
        tap(11);
        check("star_op_b", operand_b, 7);
        check("star_valid", 16'(valid_cnt - v0), 1);

        // bouncing 5
        do_reset();
        repeat (70) @(posedge clk);
        s0 = stb_cnt;
        repeat (4) begin
            keys[idx_of(5)] = 1'b1;
            repeat (16) @(posedge clk);
            keys = '0;
            repeat (16) @(posedge clk);
        end
        @(negedge clk);
        check("bounce_none", 16'(stb_cnt - s0), 0);
        tap(5);
        check("bounce_one", 16'(stb_cnt - s0), 1);
        check("bounce_unit", digit_unit, 5);

        // 3 and 6 together, then release 6
        do_reset();
        repeat (70) @(posedge clk);
        s0 = stb_cnt;
        keys[idx_of(3)] = 1'b1;
        keys[idx_of(6)] = 1'b1;
        repeat (128) @(posedge clk);
        @(negedge clk);
        check("two_none", 16'(stb_cnt - s0), 0);
        check("two_unit", digit_unit, 0);
        keys[idx_of(6)] = 1'b0;
        repeat (96) @(posedge clk);
        @(negedge clk);
        check("two_rel_stb", 16'(stb_cnt - s0), 1);
        check("two_rel_unit", digit_unit, 3);
        keys = '0;
        repeat (96) @(posedge clk);

        // reset while 9 is held
        keys[idx_of(9)] = 1'b1;
        repeat (96) @(posedge clk);
        @(negedge clk);
        check("hold9_unit", digit_unit, 9);
        do_reset();
        s0 = stb_cnt;
        v0 = valid_cnt;
        check("mid_row_n", row_n, 4'b1110);
        check("mid_unit", digit_unit, 0);
        check("mid_tens", digit_tens, 0);
        check("mid_op_a", operand_a, 0);
        check("mid_sel", entry_sel, 0);
        repeat (128) @(posedge clk);
        @(negedge clk);
        check("held_no_stb", 16'(stb_cnt - s0), 0);
        check("held_no_valid", 16'(valid_cnt - v0), 0);
        check("held_unit", digit_unit, 0);
        keys = '0;
        repeat (96) @(posedge clk);
        @(negedge clk);
        check("rel_no_stb", 16'(stb_cnt - s0), 0);
        tap(9);
        check("repress_stb", 16'(stb_cnt - s0), 1);
        check("repress_unit", digit_unit, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
